// File: rtl/bird_trace_dots_if.sv
// Pixel/position bus between the VGA timing + bird trace stage and the trace-dot drawer.
//   startOfFrame : single-cycle frame pulse
//   pixelX/Y     : current pixel (unsigned)
//   topLeftX/Y   : signed delayed bird position, qualified by draw
//   clear        : synchronous clear of all dots
//   drawingRequest / RGBout : registered hit flag and colour towards the object mux
interface bird_trace_dots_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        draw;
  logic        clear;
  logic        drawingRequest;
  logic [7:0]  RGBout;

  modport master (
    output startOfFrame, pixelX, pixelY, topLeftX, topLeftY, draw, clear,
    input  drawingRequest, RGBout
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY, draw, clear,
    output drawingRequest, RGBout
  );
endinterface

// File: rtl/bird_trace_dots.sv
// Bird trace dots: samples the delayed bird position once every CAPTURE_INTERVAL
// frames into a ring buffer of NUM_DOTS dots and draws them as small squares,
// younger half in DOT_COLOR_NEW, older half in DOT_COLOR_OLD.
// Ports:
//   clk    : pixel clock
//   resetN : asynchronous active-low reset
//   bus    : slave side of bird_trace_dots_if (pixel/position in, draw request/colour out)
module bird_trace_dots #(
  parameter int unsigned NUM_DOTS         = 8,
  parameter int unsigned CAPTURE_INTERVAL = 4,
  parameter int unsigned DOT_SIZE         = 4,
  parameter int unsigned DOT_OFFSET       = 6,
  parameter logic [7:0]  DOT_COLOR_NEW    = 8'hE0,
  parameter logic [7:0]  DOT_COLOR_OLD    = 8'h92,
  parameter logic [7:0]  TRANSPARENT      = 8'hFF
) (
  input  logic             clk,
  input  logic             resetN,
  bird_trace_dots_if.slave bus
);

  localparam int unsigned POS_W = 11;
  localparam int unsigned CMP_W = POS_W + 1;
  localparam int unsigned PTR_W = $clog2(NUM_DOTS);
  localparam int unsigned CNT_W = 4;

  localparam logic [POS_W-1:0]        OFFSET    = POS_W'(DOT_OFFSET);
  localparam logic signed [CMP_W-1:0] SIZE      = CMP_W'(DOT_SIZE);
  localparam logic [CNT_W-1:0]        CNT_FIRST = CNT_W'(1 % CAPTURE_INTERVAL);
  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(CAPTURE_INTERVAL - 1);
  localparam logic [PTR_W-1:0]        HALF      = PTR_W'(NUM_DOTS / 2);

  logic [POS_W-1:0]    dot_x [NUM_DOTS];
  logic [POS_W-1:0]    dot_y [NUM_DOTS];
  logic [NUM_DOTS-1:0] valid;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    frame_cnt;

  logic                    any_hit_c;
  logic [PTR_W-1:0]        best_age_c;
  logic [PTR_W-1:0]        age_c;
  logic signed [CMP_W-1:0] px_c, py_c, dx_c, dy_c;
  logic                    hit_c;

  // Capture: one write per CAPTURE_INTERVAL frames while draw is high; clear wins.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid     <= '0;
      wr_ptr    <= '0;
      frame_cnt <= '0;
      for (int i = 0; i < int'(NUM_DOTS); i++) begin
        dot_x[i] <= '0;
        dot_y[i] <= '0;
      end
    end else if (bus.clear) begin
      valid     <= '0;
      wr_ptr    <= '0;
      frame_cnt <= '0;
    end else if (bus.startOfFrame) begin
      if (!bus.draw) begin
        frame_cnt <= '0;
      end else if (frame_cnt == '0) begin
        dot_x[wr_ptr] <= bus.topLeftX + OFFSET;
        dot_y[wr_ptr] <= bus.topLeftY + OFFSET;
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
        frame_cnt     <= CNT_FIRST;
      end else begin
        frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CNT_W'(1);
      end
    end
  end

  // Pixel hit test against every stored dot; youngest hitting dot picks the colour.
  always_comb begin
    any_hit_c  = 1'b0;
    best_age_c = '1;
    age_c      = '0;
    hit_c      = 1'b0;
    dx_c       = '0;
    dy_c       = '0;
    px_c       = $signed({1'b0, bus.pixelX});
    py_c       = $signed({1'b0, bus.pixelY});
    for (int i = 0; i < int'(NUM_DOTS); i++) begin
      dx_c  = $signed({dot_x[i][POS_W-1], dot_x[i]});
      dy_c  = $signed({dot_y[i][POS_W-1], dot_y[i]});
      hit_c = valid[i] && (dx_c <= px_c) && (px_c < dx_c + SIZE)
                       && (dy_c <= py_c) && (py_c < dy_c + SIZE);
      // Age 0 is the slot written most recently (one behind wr_ptr).
      age_c = wr_ptr - PTR_W'(1) - PTR_W'(i);
      if (hit_c && (!any_hit_c || (age_c < best_age_c))) begin
        any_hit_c  = 1'b1;
        best_age_c = age_c;
      end
    end
  end

  // Output register: one clock from pixel coordinates to request/colour.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.drawingRequest <= 1'b0;
      bus.RGBout         <= TRANSPARENT;
    end else begin
      bus.drawingRequest <= any_hit_c;
      if (!any_hit_c) begin
        bus.RGBout <= TRANSPARENT;
      end else if (best_age_c < HALF) begin
        bus.RGBout <= DOT_COLOR_NEW;
      end else begin
        bus.RGBout <= DOT_COLOR_OLD;
      end
    end
  end

endmodule

// File: tb/tb_bird_trace_dots.sv
// Bench for bird_trace_dots: directed frames/pixel queries, expected responses queued
// at issue time and checked by an independent monitor one cycle later.
module tb_bird_trace_dots;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  bird_trace_dots_if bus ();

  bird_trace_dots dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct {
    logic       dr;
    logic [7:0] rgb;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   tag      = 0;
  logic query    = 1'b0;
  logic q_d      = 1'b0;

  always @(posedge clk) q_d <= query;

  // Monitor: the cycle after a query was presented, the registered outputs belong to it.
  always @(negedge clk) begin
    if (q_d) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_empty: output present but no expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.drawingRequest !== e.dr || bus.RGBout !== e.rgb) begin
          failures++;
          $display("FAIL q%0d: got dr=%0b rgb=%h, expected dr=%0b rgb=%h",
                   e.tag, bus.drawingRequest, bus.RGBout, e.dr, e.rgb);
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus, applied at the falling edge.
  task automatic drive(input logic sof, input logic drw, input int tx, input int ty,
                       input logic clr, input logic q, input int px, input int py,
                       input logic edr, input logic [7:0] ergb);
    @(negedge clk);
    bus.startOfFrame = sof;
    bus.draw         = drw;
    bus.topLeftX     = 11'(tx);
    bus.topLeftY     = 11'(ty);
    bus.clear        = clr;
    bus.pixelX       = 11'(px);
    bus.pixelY       = 11'(py);
    query            = q;
    if (q) begin
      sb.push_back('{edr, ergb, tag});
      tag++;
    end
  endtask

  task automatic frame(input logic drw, input int tx, input int ty);
    drive(1'b1, drw, tx, ty, 1'b0, 1'b0, 0, 0, 1'b0, 8'hFF);
  endtask

  task automatic chk(input int px, input int py, input logic edr, input logic [7:0] ergb);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, px, py, edr, ergb);
  endtask

  task automatic clr();
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 8'hFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.startOfFrame = 1'b0;
    bus.draw         = 1'b0;
    bus.topLeftX     = '0;
    bus.topLeftY     = '0;
    bus.clear        = 1'b0;
    bus.pixelX       = '0;
    bus.pixelY       = '0;

    // Reset values
    #12;
    cmp("reset_out", {bus.drawingRequest, bus.RGBout}, {1'b0, 8'hFF});
    @(negedge clk);
    resetN = 1'b1;

    // 1: single capture; same-cycle pixel is not bypassed
    drive(1'b1, 1'b1, 100, 200, 1'b0, 1'b1, 106, 206, 1'b0, 8'hFF);
    chk(106, 206, 1'b1, 8'hE0);
    chk(110, 206, 1'b0, 8'hFF);
    chk(105, 206, 1'b0, 8'hFF);
    chk(109, 209, 1'b1, 8'hE0);
    chk(106, 210, 1'b0, 8'hFF);

    // 2: 12 frames, captures on frames 0/4/8 only
    clr();
    for (int k = 0; k < 12; k++) frame(1'b1, 100 + 10 * k, 200);
    chk(106, 206, 1'b1, 8'hE0);
    chk(146, 206, 1'b1, 8'hE0);
    chk(186, 206, 1'b1, 8'hE0);
    chk(116, 206, 1'b0, 8'hFF);
    chk(156, 206, 1'b0, 8'hFF);
    chk(216, 206, 1'b0, 8'hFF);

    // 3: 40 frames -> 10 captures, dots j=0,1 overwritten, wr_ptr=2
    clr();
    for (int k = 0; k < 40; k++) frame(1'b1, 20 + 10 * k, 100);
    chk(26,  106, 1'b0, 8'hFF);
    chk(66,  106, 1'b0, 8'hFF);
    chk(106, 106, 1'b1, 8'h92);
    chk(226, 106, 1'b1, 8'h92);
    chk(229, 109, 1'b1, 8'h92);
    chk(230, 106, 1'b0, 8'hFF);
    chk(266, 106, 1'b1, 8'hE0);
    chk(386, 106, 1'b1, 8'hE0);

    // 4: new dot lands in slot 2 on top of the age-5 dot at (226,106)
    frame(1'b1, 220, 100);
    chk(226, 106, 1'b1, 8'hE0);
    chk(229, 109, 1'b1, 8'hE0);
    chk(106, 106, 1'b0, 8'hFF);
    chk(146, 106, 1'b1, 8'h92);
    chk(266, 106, 1'b1, 8'h92);
    chk(306, 106, 1'b1, 8'hE0);
    chk(386, 106, 1'b1, 8'hE0);

    // 5: draw drops mid-count, next flight captures at once; partly off-screen dot
    clr();
    frame(1'b1, -8, -8);
    frame(1'b1, 0, 0);
    frame(1'b0, 0, 0);
    frame(1'b1, 400, 300);
    chk(0,   0,   1'b1, 8'hE0);
    chk(1,   1,   1'b1, 8'hE0);
    chk(2,   0,   1'b0, 8'hFF);
    chk(406, 306, 1'b1, 8'hE0);
    chk(405, 306, 1'b0, 8'hFF);
    chk(409, 309, 1'b1, 8'hE0);

    // 6: clear beats a coinciding capture
    drive(1'b1, 1'b1, 50, 50, 1'b1, 1'b0, 0, 0, 1'b0, 8'hFF);
    chk(56, 56, 1'b0, 8'hFF);
    chk(0,  0,  1'b0, 8'hFF);
    frame(1'b1, 50, 50);
    chk(56, 56, 1'b1, 8'hE0);

    // Async reset mid-line
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 56, 56, 1'b0, 8'hFF);
    @(posedge clk);
    #2;
    cmp("pre_async_reset", {bus.drawingRequest, bus.RGBout}, {1'b1, 8'hE0});
    resetN = 1'b0;
    #1;
    cmp("async_reset", {bus.drawingRequest, bus.RGBout}, {1'b0, 8'hFF});
    @(negedge clk);
    resetN = 1'b1;
    chk(56, 56, 1'b0, 8'hFF);

    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 8'hFF);
    cmp("sb_drained", 9'(sb.size()), 9'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
